// File: rtl/escritura_pkg.sv
// Shared types and default constants for the RTC burst write sequencer.
package escritura_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    NEXT,
    XFER,
    DONE,
    ERR
  } estado_t;

  localparam logic [7:0] TIME_LO_D   = 8'h21;
  localparam logic [7:0] TIME_HI_D   = 8'h26;
  localparam logic [7:0] TIMER_LO_D  = 8'h41;
  localparam logic [7:0] TIMER_HI_D  = 8'h43;
  localparam logic [7:0] CMD_TIME_D  = 8'hF0;
  localparam logic [7:0] CMD_TIMER_D = 8'hF2;

  function automatic logic en_rango(input logic [31:0] a, input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/escritura_fifo.sv
// Synchronous request FIFO with occupancy level, flush and overflow detection.
module escritura_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic                     overflow_c,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  // A push while full is still accepted when the head leaves on the same edge.
  assign full_c     = (level == LW'(DEPTH));
  assign empty_c    = (level == '0);
  assign do_rd      = rd_en && !empty_c;
  assign do_wr      = wr_en && (!full_c || do_rd);
  assign overflow_c = wr_en && full_c && !do_rd;
  assign rd_data_c  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);
      case ({do_wr, do_rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/escritura_rafaga.sv
// Burst write sequencer: drains queued register writes onto the RTC bus, then
// issues one coalesced transfer command per register group that was touched.
module escritura_rafaga
  import escritura_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       DEPTH     = 4,
  parameter logic [ADDR_W-1:0] TIME_LO   = ADDR_W'(TIME_LO_D),
  parameter logic [ADDR_W-1:0] TIME_HI   = ADDR_W'(TIME_HI_D),
  parameter logic [ADDR_W-1:0] TIMER_LO  = ADDR_W'(TIMER_LO_D),
  parameter logic [ADDR_W-1:0] TIMER_HI  = ADDR_W'(TIMER_HI_D),
  parameter logic [7:0]        CMD_TIME  = CMD_TIME_D,
  parameter logic [7:0]        CMD_TIMER = CMD_TIMER_D,
  parameter int unsigned       TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_dir,
  input  logic [DATA_W-1:0]        push_dato,
  output logic                     push_ready,
  output logic [$clog2(DEPTH):0]   nivel,
  input  logic                     fin,
  output logic [ADDR_W-1:0]        dir_out,
  output logic [DATA_W-1:0]        data_out,
  output logic                     escribe,
  output logic                     activa,
  output logic                     final_rafaga,  // "final" is a reserved word
  output logic                     error,
  input  logic                     clr_error
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  estado_t                    estado;
  logic [CNT_W-1:0]           cnt;
  logic                       pend_time;
  logic                       pend_timer;
  logic                       xfer_time;
  logic [ADDR_W+DATA_W-1:0]   cabeza_c;
  logic                       full_c;
  logic                       empty_c;
  logic                       overflow_c;
  logic                       pop_c;
  logic                       flush_c;
  logic                       vence_c;

  assign pop_c      = ((estado == IDLE) || (estado == NEXT)) && !empty_c;
  assign flush_c    = (estado == ERR);
  assign push_ready = !full_c;
  assign vence_c    = (cnt == CNT_W'(TIMEOUT - 1));

  escritura_fifo #(
    .W     (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush_c),
    .wr_en      (push),
    .wr_data    ({push_dir, push_dato}),
    .rd_en      (pop_c),
    .rd_data_c  (cabeza_c),
    .full_c     (full_c),
    .empty_c    (empty_c),
    .overflow_c (overflow_c),
    .level      (nivel)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado       <= IDLE;
      cnt          <= '0;
      pend_time    <= 1'b0;
      pend_timer   <= 1'b0;
      xfer_time    <= 1'b0;
      dir_out      <= '0;
      data_out     <= '0;
      escribe      <= 1'b0;
      activa       <= 1'b0;
      final_rafaga <= 1'b0;
      error        <= 1'b0;
    end else begin
      final_rafaga <= 1'b0;
      // Set events dominate a simultaneous clear.
      if (overflow_c || (estado == ERR)) error <= 1'b1;
      else if (clr_error)                error <= 1'b0;

      case (estado)
        IDLE: begin
          if (!empty_c) begin
            {dir_out, data_out} <= cabeza_c;
            escribe <= 1'b1;
            activa  <= 1'b1;
            cnt     <= '0;
            estado  <= WRITE;
          end
        end
        WRITE: begin
          if (fin) begin
            escribe <= 1'b0;
            if (en_rango(32'(dir_out), 32'(TIME_LO), 32'(TIME_HI)))   pend_time  <= 1'b1;
            if (en_rango(32'(dir_out), 32'(TIMER_LO), 32'(TIMER_HI))) pend_timer <= 1'b1;
            estado <= NEXT;
          end else if (vence_c) begin
            escribe <= 1'b0;
            estado  <= ERR;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        NEXT: begin
          if (!empty_c) begin
            {dir_out, data_out} <= cabeza_c;
            escribe <= 1'b1;
            cnt     <= '0;
            estado  <= WRITE;
          end else if (pend_time || pend_timer) begin
            dir_out   <= pend_time ? ADDR_W'(CMD_TIME) : ADDR_W'(CMD_TIMER);
            data_out  <= pend_time ? DATA_W'(CMD_TIME) : DATA_W'(CMD_TIMER);
            xfer_time <= pend_time;
            escribe   <= 1'b1;
            cnt       <= '0;
            estado    <= XFER;
          end else begin
            estado <= DONE;
          end
        end
        XFER: begin
          if (fin) begin
            if (xfer_time) pend_time  <= 1'b0;
            else           pend_timer <= 1'b0;
            escribe <= 1'b0;
            estado  <= NEXT;
          end else if (vence_c) begin
            escribe <= 1'b0;
            estado  <= ERR;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          final_rafaga <= 1'b1;
          dir_out      <= '0;
          data_out     <= '0;
          escribe      <= 1'b0;
          activa       <= 1'b0;
          estado       <= IDLE;
        end
        ERR: begin
          final_rafaga <= 1'b1;
          pend_time    <= 1'b0;
          pend_timer   <= 1'b0;
          dir_out      <= '0;
          data_out     <= '0;
          escribe      <= 1'b0;
          activa       <= 1'b0;
          estado       <= IDLE;
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_escritura_rafaga.sv
// Self-checking bench for escritura_rafaga: directed scenarios plus randomized
// bursts checked against a queue-based model of the expected bus traffic.
module tb_escritura_rafaga;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic [7:0] push_dir;
  logic [7:0] push_dato;
  logic       push_ready;
  logic [2:0] nivel;
  logic       fin;
  logic [7:0] dir_out;
  logic [7:0] data_out;
  logic       escribe;
  logic       activa;
  logic       final_rafaga;
  logic       error;
  logic       clr_error;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] exp_q[$];
  logic [15:0] extra_q[$];

  escritura_rafaga #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .push_dir     (push_dir),
    .push_dato    (push_dato),
    .push_ready   (push_ready),
    .nivel        (nivel),
    .fin          (fin),
    .dir_out      (dir_out),
    .data_out     (data_out),
    .escribe      (escribe),
    .activa       (activa),
    .final_rafaga (final_rafaga),
    .error        (error),
    .clr_error    (clr_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic empujar(input logic [7:0] d, input logic [7:0] v);
    push_dir  = d;
    push_dato = v;
    push      = 1'b1;
    tick();
    push      = 1'b0;
  endtask

  task automatic esperar_escribe(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (escribe) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
    chk("espera_escribe", 32'(escribe), 32'd1);
  endtask

  function automatic bit es_time(input logic [7:0] a);
    return (a >= 8'h21) && (a <= 8'h26);
  endfunction

  function automatic bit es_timer(input logic [7:0] a);
    return (a >= 8'h41) && (a <= 8'h43);
  endfunction

  // Model: all accepted writes in push order, then F0 if any time-group address
  // was written, then F2 if any timer-group address was written.
  task automatic agregar_comandos();
    bit t = 1'b0;
    bit r = 1'b0;
    foreach (exp_q[i]) begin
      if (es_time(exp_q[i][15:8]))  t = 1'b1;
      if (es_timer(exp_q[i][15:8])) r = 1'b1;
    end
    if (t) exp_q.push_back(16'hF0F0);
    if (r) exp_q.push_back(16'hF2F2);
  endtask

  // Acts as the bus controller for every expected transaction, then checks the
  // end-of-burst pulse. fin_dly < 0 picks a random completion delay.
  task automatic servir(input int fin_dly);
    int          n;
    int          d;
    bit          ok;
    logic [15:0] e;
    logic [15:0] x;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q[i];
      if (i == 0) begin
        esperar_escribe(ok);
        if (!ok) return;
        while (extra_q.size() > 0) begin
          x = extra_q.pop_front();
          empujar(x[15:8], x[7:0]);
        end
      end else begin
        chk("escribe_tras_hueco", 32'(escribe), 32'd1);
      end
      chk("dir_out", 32'(dir_out), 32'(e[15:8]));
      chk("data_out", 32'(data_out), 32'(e[7:0]));
      chk("activa", 32'(activa), 32'd1);
      d = (fin_dly < 0) ? int'($urandom_range(0, 3)) : fin_dly;
      repeat (d) tick();
      fin = 1'b1;
      tick();
      fin = 1'b0;
      chk("escribe_baja", 32'(escribe), 32'd0);
      tick();
    end
    chk("final_antes", 32'(final_rafaga), 32'd0);
    tick();
    chk("final", 32'(final_rafaga), 32'd1);
    chk("activa_fin", 32'(activa), 32'd0);
    chk("dir_out_fin", 32'(dir_out), 32'd0);
    tick();
    chk("final_un_ciclo", 32'(final_rafaga), 32'd0);
    chk("nivel_fin", 32'(nivel), 32'd0);
    exp_q.delete();
  endtask

  function automatic logic [7:0] dir_azar();
    case ($urandom_range(0, 3))
      0:       return 8'($urandom_range(8'h21, 8'h26));
      1:       return 8'($urandom_range(8'h41, 8'h43));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    int          cnt;
    int          n;
    int          e;
    bit          ok;
    logic [15:0] r;

    reset = 1'b1; push = 1'b0; push_dir = '0; push_dato = '0;
    fin = 1'b0; clr_error = 1'b0;
    repeat (3) tick();
    chk("rst_escribe", 32'(escribe), 32'd0);
    chk("rst_activa", 32'(activa), 32'd0);
    chk("rst_dir", 32'(dir_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_final", 32'(final_rafaga), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_nivel", 32'(nivel), 32'd0);
    chk("rst_push_ready", 32'(push_ready), 32'd1);
    @(negedge clk) reset = 1'b0;
    tick();

    // fin while idle has no effect
    fin = 1'b1; tick(); tick(); fin = 1'b0;
    chk("fin_ocioso_activa", 32'(activa), 32'd0);
    chk("fin_ocioso_final", 32'(final_rafaga), 32'd0);

    // Single write, no group touched
    empujar(8'h10, 8'h55);
    exp_q.push_back(16'h1055);
    servir(3);
    chk("simple_error", 32'(error), 32'd0);

    // Time group burst: three writes then one F0
    empujar(8'h21, 8'h01); empujar(8'h22, 8'h02); empujar(8'h26, 8'h03);
    exp_q = '{16'h2101, 16'h2202, 16'h2603};
    agregar_comandos();
    chk("modelo_time_len", 32'(exp_q.size()), 32'd4);
    servir(1);

    // Mixed groups: F0 then F2
    empujar(8'h24, 8'hA4); empujar(8'h42, 8'hB2);
    exp_q = '{16'h24A4, 16'h42B2};
    agregar_comandos();
    servir(-1);

    // Overflow: fin held low, 6 pushes, only 1 in flight + DEPTH queued survive
    for (int i = 0; i < 6; i++) begin
      r = {8'h30 + 8'(i), 8'($urandom_range(0, 255))};
      if (i < DEPTH + 1) exp_q.push_back(r);
      if (i == 5) clr_error = 1'b1;
      empujar(r[15:8], r[7:0]);
      clr_error = 1'b0;
    end
    chk("ovf_push_ready", 32'(push_ready), 32'd0);
    chk("ovf_nivel", 32'(nivel), 32'(DEPTH));
    chk("ovf_error_gana", 32'(error), 32'd1);
    servir(0);
    chk("ovf_error_persiste", 32'(error), 32'd1);
    clr_error = 1'b1; tick(); clr_error = 1'b0;
    chk("clr_error", 32'(error), 32'd0);

    // Timeout: fin never comes; two extra requests queued then flushed
    empujar(8'h50, 8'h11);
    esperar_escribe(ok);
    cnt = 0;
    while (escribe && cnt < 50) begin
      cnt++;
      if (cnt <= 2) begin
        push_dir = 8'h51 + 8'(cnt); push_dato = 8'h22; push = 1'b1;
      end else begin
        push = 1'b0;
      end
      tick();
    end
    push = 1'b0;
    chk("timeout_ciclos", 32'(cnt), 32'(TIMEOUT));
    chk("timeout_nivel_antes", 32'(nivel), 32'd2);
    tick();
    chk("timeout_final", 32'(final_rafaga), 32'd1);
    chk("timeout_error", 32'(error), 32'd1);
    chk("timeout_nivel", 32'(nivel), 32'd0);
    chk("timeout_activa", 32'(activa), 32'd0);
    repeat (4) tick();
    chk("timeout_sin_escribe", 32'(escribe), 32'd0);
    chk("timeout_error_pegado", 32'(error), 32'd1);
    clr_error = 1'b1; tick(); clr_error = 1'b0;
    chk("timeout_clr", 32'(error), 32'd0);

    // Reset while the F0 command is on the bus
    empujar(8'h23, 8'hAA);
    esperar_escribe(ok);
    chk("rx_dir", 32'(dir_out), 32'h23);
    fin = 1'b1; tick(); fin = 1'b0; tick();
    chk("rx_cmd_dir", 32'(dir_out), 32'hF0);
    chk("rx_cmd_escribe", 32'(escribe), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rx_escribe", 32'(escribe), 32'd0);
    chk("rx_activa", 32'(activa), 32'd0);
    chk("rx_dir0", 32'(dir_out), 32'd0);
    chk("rx_data0", 32'(data_out), 32'd0);
    chk("rx_nivel", 32'(nivel), 32'd0);
    tick(); tick();
    chk("rx_sin_final", 32'(final_rafaga), 32'd0);
    @(negedge clk) reset = 1'b0;
    tick();
    empujar(8'h10, 8'h55);
    exp_q.push_back(16'h1055);
    servir(2);

    // Randomized bursts, some requests joining while the first write is open
    for (int it = 0; it < 20; it++) begin
      n = int'($urandom_range(1, DEPTH));
      e = int'($urandom_range(0, DEPTH - n + 1));
      for (int i = 0; i < n; i++) begin
        r = {dir_azar(), 8'($urandom_range(0, 255))};
        exp_q.push_back(r);
      end
      for (int i = 0; i < e; i++) begin
        r = {dir_azar(), 8'($urandom_range(0, 255))};
        exp_q.push_back(r);
        extra_q.push_back(r);
      end
      agregar_comandos();
      for (int i = 0; i < n; i++) empujar(exp_q[i][15:8], exp_q[i][7:0]);
      servir(-1);
      chk("azar_error", 32'(error), 32'd0);
      repeat (int'($urandom_range(0, 3))) tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
